urisc_phase_sequencer: RTL and testbench
========================================

# urisc_phase_sequencer

Sequencer that drives the URISC datapath through its per-instruction execution phases. It emits one-hot phase *enables* for the datapath registers; these are synchronous enables on `clkIn`, not divided or gated clocks. Phases that touch memory are held until a `memReq`/`memAck` handshake completes. The block supports start, halt at instruction boundaries, and instruction counting, and sits between the top-level control inputs and the datapath/memory interface.

## Interface
- `NUM_PHASES`, default 4: phases per instruction; must be ≥ 2.
- `MEM_PHASE_MASK`, default 4'b0111: bit i = 1 means phase i requires a memory handshake; width is `NUM_PHASES`.
- `COUNT_W`, default 32: width of the retired-instruction counter.
- `clkIn`, input, 1: the single clock; all state changes on its rising edge.
- `rstN`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin or resume execution; sampled only in IDLE or HALTED.
- `haltReq`, input, 1: request a stop at the next instruction boundary; single-cycle pulse is enough.
- `memAck`, input, 1: memory completed the current phase's access.
- `phaseEn`, output, `NUM_PHASES`: one-hot phase enable; all zero when not running.
- `phaseIdx`, output, `$clog2(NUM_PHASES)`: binary index of the active phase; 0 when not running.
- `memReq`, output, 1: memory access requested for the active phase.
- `instrDone`, output, 1: one-cycle pulse per retired instruction.
- `busy`, output, 1: high in RUN.
- `halted`, output, 1: high in HALTED.
- `instrCount`, output, `COUNT_W`: number of retired instructions; wraps modulo 2^`COUNT_W`.

## Operation
- **States:** IDLE (reset state), RUN, HALTED.
- **IDLE or HALTED, `start`=1:** go to RUN with phase 0; clear the pending-halt latch, unless `haltReq` is also 1 in this cycle.
- **RUN, non-memory phase** (mask bit 0): advance one phase every cycle.
- **RUN, memory phase** (mask bit 1): `memReq`=1; phase held until `memAck` is sampled 1, then advance.
  - `memAck` sampled when `memReq`=0 is ignored.
- **`haltReq` in RUN:** sets a sticky pending-halt latch; it never truncates an instruction.
- **Completion of the last phase:**
  - `instrDone` pulses and `instrCount` increments.
  - Pending halt set: go to HALTED and clear the latch.
  - Otherwise: wrap to phase 0.
- **`start` in RUN:** ignored.
- **`start` and `haltReq` together in IDLE/HALTED:** start wins and the halt is latched; exactly one instruction executes, then HALTED.
- **`instrCount`:** cleared only by reset; HALTED preserves it.

## Timing
- **Registered outputs:** all outputs are registered. Reset values: `phaseEn`=0, `phaseIdx`=0, `memReq`=0, `instrDone`=0, `busy`=0, `halted`=0, `instrCount`=0.
- **Start latency:** `start` sampled at edge k gives `phaseEn`=phase 0 and `busy`=1 after edge k.
- **Memory phase duration:** minimum 1 cycle. `memAck`=1 in the first cycle of a phase advances at the next edge.
- **`memReq` across phases:** updates with `phaseEn`. It stays high across consecutive memory phases and must not glitch low between them.
- **`instrDone`:** high in the cycle after the last phase. That cycle shows either `phaseEn`=phase 0 of the next instruction or the first HALTED cycle.
- **`instrCount`:** updates in the same cycle as `instrDone`.
- **Reset mid-operation:** asserting `rstN` clears all outputs immediately, without waiting for a clock edge, including an in-flight `memReq`; the state returns to IDLE. The first `start` is accepted on the first edge after deassertion.

## Configuration
- **Macro `URISC_SINGLE_STEP_EN`:**
  - Defined: adds an input port `stepMode` (1 bit). When `stepMode`=1 at an instruction boundary, the block behaves as if a halt were pending and goes to HALTED. Each subsequent `start` executes exactly one instruction.
  - Undefined: the port is absent and the behaviour is exactly as described above.

## Structure
- **Package `urisc_pkg`:** holds the `seq_state_t` enum (IDLE, RUN, HALTED) and the default phase constants shared with the datapath (`URISC_NUM_PHASES`=4, `URISC_MEM_PHASE_MASK`).
- **Sub-module `phase_ring`:** one-hot rotating register with synchronous load-to-phase-0, advance-enable and clear. The sequencer FSM, the pending-halt latch, the handshake logic and the counter stay in the top module.

## Test plan
- **Basic run:** `NUM_PHASES`=4, mask 0111, `memAck` tied 1, `start` pulse at cycle 0 → `phaseEn` = 0001, 0010, 0100, 1000 on cycles 1–4; at cycle 5, `phaseEn`=0001, `instrDone`=1, `instrCount`=1. `memReq`=1 on cycles 1–3 and 0 on cycle 4.
- **Memory stall:** `memAck` held 0 for 3 cycles in phase 1 → `phaseEn`=0010 held 4 cycles, `phaseIdx`=1 throughout, `memReq` continuously 1, then advance to 0100.
- **Halt mid-instruction:** `haltReq` pulse during phase 1 → phases 2 and 3 complete, then `instrDone`=1, `halted`=1, `busy`=0, `phaseEn`=0. A later `start` → `phaseEn`=0001 one cycle later, `instrCount` continues from its previous value.
- **Simultaneous start and halt:** `start` and `haltReq` in the same cycle from IDLE → exactly one `instrDone`, then HALTED.
- **Asynchronous reset:** `rstN` driven low mid-phase 2 with `memReq`=1 → all outputs 0 before the next clock edge; `instrCount`=0; the state is IDLE after release.
- **Single step (`URISC_SINGLE_STEP_EN`):** `stepMode`=1, three `start` pulses → three instructions, each ending in HALTED, `instrCount`=3.

Source files
------------

// File: rtl/urisc_phase_sequencer_pkg.sv
// Shared URISC sequencer types and datapath phase defaults.
// Consumed by the sequencer, its interface and the datapath.
package urisc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } seq_state_t;

  localparam int URISC_NUM_PHASES = 4;
  localparam logic [3:0] URISC_MEM_PHASE_MASK = 4'b0111;

endpackage

// File: rtl/urisc_phase_sequencer_if.sv
// Phase/memory bundle between the sequencer and the datapath.
// The master drives the phase enables and memReq; the slave returns memAck.
interface urisc_phase_sequencer_if
  import urisc_pkg::*;
#(
  parameter int NUM_PHASES = URISC_NUM_PHASES
);
  localparam int IW = $clog2(NUM_PHASES);

  logic [NUM_PHASES-1:0] phaseEn;
  logic [IW-1:0]         phaseIdx;
  logic                  memReq;
  logic                  memAck;
  logic                  instrDone;

  modport master (
    output phaseEn,
    output phaseIdx,
    output memReq,
    output instrDone,
    input  memAck
  );

  modport slave (
    input  phaseEn,
    input  phaseIdx,
    input  memReq,
    input  instrDone,
    output memAck
  );
endinterface

// File: rtl/urisc_phase_sequencer_phase_ring.sv
// One-hot rotating phase register.
// Clear beats load-to-phase-0, which beats advance.
module phase_ring #(
  parameter int N = 4
) (
  input  logic         clkIn,
  input  logic         rstN,
  input  logic         load,
  input  logic         adv,
  input  logic         clr,
  output logic [N-1:0] q
);

  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= {{(N-1){1'b0}}, 1'b1};
    end else if (adv) begin
      q <= {q[N-2:0], q[N-1]};
    end
  end

endmodule

// File: rtl/urisc_phase_sequencer.sv
// URISC per-instruction phase sequencer with memory handshake and halt.
// Optional URISC_SINGLE_STEP_EN adds a stepMode input.
module urisc_phase_sequencer
  import urisc_pkg::*;
#(
  parameter int                    NUM_PHASES     = URISC_NUM_PHASES,
  parameter logic [NUM_PHASES-1:0] MEM_PHASE_MASK = URISC_MEM_PHASE_MASK,
  parameter int                    COUNT_W        = 32
) (
  input  logic               clkIn,
  input  logic               rstN,
  input  logic               start,
  input  logic               haltReq,
`ifdef URISC_SINGLE_STEP_EN
  input  logic               stepMode,
`endif
  urisc_phase_sequencer_if.master bus,
  output logic               busy,
  output logic               halted,
  output logic [COUNT_W-1:0] instrCount
);

  localparam int IW = $clog2(NUM_PHASES);
  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] RUN    = ST_RUN;
  localparam logic [1:0] HALTED = ST_HALTED;

  logic [1:0]            state;
  logic                  haltPend;
  logic [NUM_PHASES-1:0] ring;
  logic [NUM_PHASES-1:0] nextRing;
  logic                  stepHalt;
  logic                  running;
  logic                  startGo;
  logic                  advance;
  logic                  lastPh;
  logic                  finish;
  logic                  stopNow;
  logic                  wrapNow;
  logic                  stepNow;

`ifdef URISC_SINGLE_STEP_EN
  assign stepHalt = stepMode;
`else
  assign stepHalt = 1'b0;
`endif

  assign running  = (state == RUN);
  assign startGo  = ((state == IDLE) || (state == HALTED)) && start;
  // memAck only counts while a request is outstanding
  assign advance  = running && (!bus.memReq || bus.memAck);
  assign lastPh   = ring[NUM_PHASES-1];
  assign finish   = advance && lastPh;
  assign stopNow  = finish && (haltPend || haltReq || stepHalt);
  assign wrapNow  = finish && !stopNow;
  assign stepNow  = advance && !lastPh;
  assign nextRing = {ring[NUM_PHASES-2:0], ring[NUM_PHASES-1]};

  phase_ring #(
    .N(NUM_PHASES)
  ) uRing (
    .clkIn(clkIn),
    .rstN (rstN),
    .load (startGo || wrapNow),
    .adv  (stepNow),
    .clr  (stopNow),
    .q    (ring)
  );

  assign bus.phaseEn = ring;

  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      state         <= IDLE;
      haltPend      <= 1'b0;
      bus.phaseIdx  <= '0;
      bus.memReq    <= 1'b0;
      bus.instrDone <= 1'b0;
      busy          <= 1'b0;
      halted        <= 1'b0;
      instrCount    <= '0;
    end else begin
      bus.instrDone <= 1'b0;
      if (running && haltReq) begin
        haltPend <= 1'b1;
      end
      unique case (1'b1)
        startGo: begin
          state        <= RUN;
          busy         <= 1'b1;
          halted       <= 1'b0;
          haltPend     <= haltReq;
          bus.phaseIdx <= '0;
          bus.memReq   <= MEM_PHASE_MASK[0];
        end
        stopNow: begin
          state         <= HALTED;
          busy          <= 1'b0;
          halted        <= 1'b1;
          haltPend      <= 1'b0;
          bus.phaseIdx  <= '0;
          bus.memReq    <= 1'b0;
          bus.instrDone <= 1'b1;
          instrCount    <= instrCount + 1'b1;
        end
        wrapNow: begin
          bus.phaseIdx  <= '0;
          bus.memReq    <= MEM_PHASE_MASK[0];
          bus.instrDone <= 1'b1;
          instrCount    <= instrCount + 1'b1;
        end
        stepNow: begin
          bus.phaseIdx <= bus.phaseIdx + 1'b1;
          bus.memReq   <= |(nextRing & MEM_PHASE_MASK);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_urisc_phase_sequencer.sv
// Directed-vector bench for urisc_phase_sequencer (4 phases, mask 0111).
// Define URISC_SINGLE_STEP_EN to also exercise stepMode.
module tb_urisc_phase_sequencer;
  import urisc_pkg::*;

  logic        clkIn;
  logic        rstN;
  logic        start;
  logic        haltReq;
  logic        busy;
  logic        halted;
  logic [31:0] instrCount;
`ifdef URISC_SINGLE_STEP_EN
  logic        stepMode;
`endif

  int nVec;
  int nMiss;

  urisc_phase_sequencer_if #(.NUM_PHASES(4)) bus ();

  urisc_phase_sequencer #(
    .NUM_PHASES    (4),
    .MEM_PHASE_MASK(4'b0111),
    .COUNT_W       (32)
  ) dut (
    .clkIn     (clkIn),
    .rstN      (rstN),
    .start     (start),
    .haltReq   (haltReq),
`ifdef URISC_SINGLE_STEP_EN
    .stepMode  (stepMode),
`endif
    .bus       (bus.master),
    .busy      (busy),
    .halted    (halted),
    .instrCount(instrCount)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMiss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic chkRun(input string tag, input logic [3:0] en,
                        input logic [1:0] idx, input logic req,
                        input logic done, input logic [31:0] cnt);
    chk({tag, ".phaseEn"}, {28'd0, bus.phaseEn}, {28'd0, en});
    chk({tag, ".phaseIdx"}, {30'd0, bus.phaseIdx}, {30'd0, idx});
    chk({tag, ".memReq"}, {31'd0, bus.memReq}, {31'd0, req});
    chk({tag, ".instrDone"}, {31'd0, bus.instrDone}, {31'd0, done});
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    chk({tag, ".halted"}, {31'd0, halted}, 32'd0);
    chk({tag, ".count"}, instrCount, cnt);
  endtask

  task automatic chkStop(input string tag, input logic hlt,
                         input logic done, input logic [31:0] cnt);
    chk({tag, ".phaseEn"}, {28'd0, bus.phaseEn}, 32'd0);
    chk({tag, ".phaseIdx"}, {30'd0, bus.phaseIdx}, 32'd0);
    chk({tag, ".memReq"}, {31'd0, bus.memReq}, 32'd0);
    chk({tag, ".instrDone"}, {31'd0, bus.instrDone}, {31'd0, done});
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, hlt});
    chk({tag, ".count"}, instrCount, cnt);
  endtask

  initial begin
    nVec = 0;
    nMiss = 0;
    rstN = 1'b0;
    start = 1'b0;
    haltReq = 1'b0;
    bus.memAck = 1'b1;
`ifdef URISC_SINGLE_STEP_EN
    stepMode = 1'b0;
`endif
    #2;
    chkStop("rst", 1'b0, 1'b0, 32'd0);
    #20;
    rstN = 1'b1;
    tick();
    chkStop("idle", 1'b0, 1'b0, 32'd0);

    // basic run, memAck tied high
    start = 1'b1;
    tick();
    start = 1'b0;
    chkRun("b1", 4'b0001, 2'd0, 1'b1, 1'b0, 32'd0);
    tick();
    chkRun("b2", 4'b0010, 2'd1, 1'b1, 1'b0, 32'd0);
    tick();
    chkRun("b3", 4'b0100, 2'd2, 1'b1, 1'b0, 32'd0);
    tick();
    chkRun("b4", 4'b1000, 2'd3, 1'b0, 1'b0, 32'd0);
    tick();
    chkRun("b5", 4'b0001, 2'd0, 1'b1, 1'b1, 32'd1);

    // stall phase 1 for three cycles
    tick();
    chkRun("s0", 4'b0010, 2'd1, 1'b1, 1'b0, 32'd1);
    bus.memAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      tick();
      chkRun("stall", 4'b0010, 2'd1, 1'b1, 1'b0, 32'd1);
    end
    start = 1'b0;
    bus.memAck = 1'b1;
    tick();
    chkRun("s4", 4'b0100, 2'd2, 1'b1, 1'b0, 32'd1);
    tick();
    chkRun("s5", 4'b1000, 2'd3, 1'b0, 1'b0, 32'd1);
    tick();
    chkRun("s6", 4'b0001, 2'd0, 1'b1, 1'b1, 32'd2);

    // halt request during phase 1
    tick();
    chkRun("h1", 4'b0010, 2'd1, 1'b1, 1'b0, 32'd2);
    haltReq = 1'b1;
    tick();
    haltReq = 1'b0;
    chkRun("h2", 4'b0100, 2'd2, 1'b1, 1'b0, 32'd2);
    tick();
    chkRun("h3", 4'b1000, 2'd3, 1'b0, 1'b0, 32'd2);
    tick();
    chkStop("h4", 1'b1, 1'b1, 32'd3);
    tick();
    chkStop("h5", 1'b1, 1'b0, 32'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chkRun("r1", 4'b0001, 2'd0, 1'b1, 1'b0, 32'd3);
    tick();
    tick();

    // async reset in phase 2 with memReq high
    chkRun("a0", 4'b0100, 2'd2, 1'b1, 1'b0, 32'd3);
    #3;
    rstN = 1'b0;
    #1;
    chkStop("a1", 1'b0, 1'b0, 32'd0);
    #2;
    rstN = 1'b1;
    tick();
    chkStop("a2", 1'b0, 1'b0, 32'd0);

    // start and halt together from IDLE
    start = 1'b1;
    haltReq = 1'b1;
    tick();
    start = 1'b0;
    haltReq = 1'b0;
    chkRun("sh1", 4'b0001, 2'd0, 1'b1, 1'b0, 32'd0);
    tick();
    tick();
    tick();
    chkRun("sh4", 4'b1000, 2'd3, 1'b0, 1'b0, 32'd0);
    tick();
    chkStop("sh5", 1'b1, 1'b1, 32'd1);
    tick();
    chkStop("sh6", 1'b1, 1'b0, 32'd1);

`ifdef URISC_SINGLE_STEP_EN
    stepMode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chkRun("st1", 4'b0001, 2'd0, 1'b1, 1'b0, 32'(k + 1));
      tick();
      tick();
      tick();
      tick();
      chkStop("st5", 1'b1, 1'b1, 32'(k + 2));
    end
    chk("stepCount", instrCount - 32'd1, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
